// File: rtl/dice_roll_scheduler_pkg.sv
// Shared types and constants for the dice roll scheduler.
// Holds die-select codes, FSM states and datapath widths.
package dice_pkg;

  localparam int SUM_W = 12;
  localparam int CNT_W = 4;
  localparam int NUM_W = 8;

  localparam logic [1:0] DIE_0       = 2'b00;
  localparam logic [1:0] DIE_1       = 2'b01;
  localparam logic [1:0] DIE_2       = 2'b10;
  localparam logic [1:0] DIE_INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ROLL = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/dice_roll_scheduler_if.sv
// Requester-side request/response bundle of the scheduler.
// master: requesters; slave: the scheduler.
import dice_pkg::*;

interface dice_roll_scheduler_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [2*NUM_REQ-1:0]     req_die;
  logic [CNT_W*NUM_REQ-1:0] req_count;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [SUM_W-1:0]         rsp_sum;
  logic                     rsp_error;

  modport master (
    output req_valid, req_die, req_count,
    input  req_ready, rsp_valid, rsp_sum, rsp_error
  );

  modport slave (
    input  req_valid, req_die, req_count,
    output req_ready, rsp_valid, rsp_sum, rsp_error
  );

endinterface

// File: rtl/dice_roll_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr.
// Ports: req, rr_ptr in; one-hot gnt and gnt_idx out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt == '0 &&
          req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
        gnt_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Shares one dice_roller between NUM_REQ requesters, sums N rolls each.
// Ports: clk, reset_n, bus (slave), roller_die_select/roll out, roller_number in.
import dice_pkg::*;

module dice_roll_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int RESULT_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  dice_roll_scheduler_if.slave bus,
  output logic [1:0]       roller_die_select,
  output logic             roller_roll,
  input  logic [NUM_W-1:0] roller_number
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WT_W  = $clog2(RESULT_LAT + 1);

  state_t state_q, state_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   g_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [1:0]         die_q;
  logic [CNT_W-1:0]   rem_q;
  logic [SUM_W-1:0]   sum_q;
  logic [WT_W-1:0]    wait_q;
  logic [SUM_W-1:0]   rsp_sum_q;
  logic               rsp_err_q;

  logic               xfer;
  logic [1:0]         new_die;
  logic [CNT_W-1:0]   new_cnt;
  logic [CNT_W-1:0]   rem_init;
  logic               new_bad;
  logic               last_wait;
  logic               rem_last;
  logic [SUM_W-1:0]   sum_acc;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  // gnt only has a bit set where req_valid is set, so this is valid&ready
  assign xfer     = (state_q == IDLE) && (|gnt);
  assign new_die  = bus.req_die[2*int'(gnt_idx) +: 2];
  assign new_cnt  = bus.req_count[CNT_W*int'(gnt_idx) +: CNT_W];
  assign rem_init = (new_cnt == '0) ? CNT_W'(1) : new_cnt;
  assign new_bad  = (new_die == DIE_INVALID);

  assign last_wait = (state_q == WAIT) && (wait_q == WT_W'(1));
  assign rem_last  = (rem_q == CNT_W'(1));
  assign sum_acc   = sum_q +
                     {{(SUM_W-NUM_W){1'b0}}, roller_number};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (xfer) state_d = new_bad ? DONE : ROLL;
      ROLL: state_d = WAIT;
      WAIT: if (last_wait) state_d = rem_last ? DONE : ROLL;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q       <= '0;
      rr_ptr_q  <= '0;
      die_q     <= '0;
      rem_q     <= '0;
      sum_q     <= '0;
      wait_q    <= '0;
      rsp_sum_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (xfer) begin
        g_q   <= gnt_idx;
        die_q <= new_die;
        rem_q <= rem_init;
        sum_q <= '0;
        if (new_bad) begin
          rsp_sum_q <= '0;
          rsp_err_q <= 1'b1;
        end
      end
      if (state_q == ROLL) wait_q <= WT_W'(RESULT_LAT);
      if (state_q == WAIT) begin
        wait_q <= wait_q - WT_W'(1);
        if (last_wait) begin
          sum_q <= sum_acc;
          rem_q <= rem_q - CNT_W'(1);
          // response registers load on DONE entry only
          if (rem_last) begin
            rsp_sum_q <= sum_acc;
            rsp_err_q <= 1'b0;
          end
        end
      end
      if (state_q == DONE) begin
        rr_ptr_q <= (g_q == IDX_W'(NUM_REQ-1)) ?
                    '0 : g_q + IDX_W'(1);
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? gnt : '0;
  assign bus.rsp_valid = (state_q == DONE) ?
                         (NUM_REQ'(1) << g_q) : '0;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_error = rsp_err_q;

  assign roller_roll       = (state_q == ROLL);
  assign roller_die_select = die_q;

endmodule
